// File: rtl/proc_pipe2_dpath_if.sv
// Instruction-fetch and data-memory bus of the two-stage TinyRV1 datapath.
// master = datapath side, slave = memory side.
interface proc_pipe2_dpath_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        dmem_reqval;
  logic        dmem_reqrdy;
  logic        dmem_wen;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;

  modport master (
    output imem_addr,
    input  imem_rdata,
    output dmem_reqval,
    input  dmem_reqrdy,
    output dmem_wen,
    output dmem_addr,
    output dmem_wdata,
    input  dmem_rdata
  );

  modport slave (
    input  imem_addr,
    output imem_rdata,
    input  dmem_reqval,
    output dmem_reqrdy,
    input  dmem_wen,
    input  dmem_addr,
    input  dmem_wdata,
    output dmem_rdata
  );
endinterface

// File: rtl/proc_pipe2_dpath.sv
// Two-stage (Fetch/Execute) TinyRV1 datapath with an iterative multiplier and a
// val/rdy data-memory port; decoded control for the X instruction comes from outside.
module proc_pipe2_dpath #(
  parameter logic [31:0] RESET_PC      = 32'h0000_0200,
  parameter int          MUL_STEP_BITS = 4
) (
  input  logic               clk,
  input  logic               rst,
  proc_pipe2_dpath_if.master mem,
  input  logic               op2_sel,
  input  logic [1:0]         wb_sel,
  input  logic [1:0]         imm_type,
  input  logic               rf_wen,
  input  logic [1:0]         pc_sel,
  input  logic               alu_func,
  input  logic               mul_req,
  input  logic               mem_req,
  input  logic               mem_wr,
  output logic [31:0]        inst_X,
  output logic               val_X,
  output logic               alu_eq,
  output logic               stall,
  output logic               mul_busy,
  output logic               trace_val,
  output logic [31:0]        trace_addr,
  output logic [4:0]         trace_wreg,
  output logic [31:0]        trace_wdata
);
  localparam int N  = 32 / MUL_STEP_BITS;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {MUL_IDLE, MUL_BUSY, MUL_DONE} mul_state_t;

  logic [31:0] pc_f_reg, pc_x_reg, inst_x_reg;
  logic        val_x_reg;
  logic [31:0] rf_reg [32];

  mul_state_t  mul_state_reg;
  logic [CW-1:0] mul_cnt_reg;
  logic [31:0] mcand_reg, mplier_reg, acc_reg;
  logic        mul_busy_reg;
  logic [31:0] pp_term [MUL_STEP_BITS];
  logic [31:0] pp_sum;

  logic [4:0]  rs1_addr, rs2_addr, rd_addr;
  logic [31:0] rs1_data, rs2_data, imm, alu_in1, alu_out, pc_plus4_x, target, wb_data;
  logic        retire, rf_write;

  assign rs1_addr = inst_x_reg[19:15];
  assign rs2_addr = inst_x_reg[24:20];
  assign rd_addr  = inst_x_reg[11:7];
  assign rs1_data = (rs1_addr == 5'd0) ? 32'd0 : rf_reg[rs1_addr];
  assign rs2_data = (rs2_addr == 5'd0) ? 32'd0 : rf_reg[rs2_addr];

  always_comb begin
    imm = '0;
    case (imm_type)
      2'd0: imm = {{20{inst_x_reg[31]}}, inst_x_reg[31:20]};
      2'd1: imm = {{20{inst_x_reg[31]}}, inst_x_reg[31:25], inst_x_reg[11:7]};
      2'd2: imm = {{11{inst_x_reg[31]}}, inst_x_reg[31], inst_x_reg[19:12],
                   inst_x_reg[20], inst_x_reg[30:21], 1'b0};
      default: imm = {{19{inst_x_reg[31]}}, inst_x_reg[31], inst_x_reg[7],
                      inst_x_reg[30:25], inst_x_reg[11:8], 1'b0};
    endcase
  end

  assign alu_in1    = op2_sel ? imm : rs2_data;
  assign alu_out    = alu_func ? {31'd0, rs1_data == alu_in1} : rs1_data + alu_in1;
  assign alu_eq     = alu_func & alu_out[0];
  assign pc_plus4_x = pc_x_reg + 32'd4;
  assign target     = (pc_sel == 2'd2) ? rs1_data : pc_x_reg + imm;

  always_comb begin
    wb_data = mem.dmem_rdata;
    case (wb_sel)
      2'd0:    wb_data = pc_plus4_x;
      2'd1:    wb_data = acc_reg;
      2'd2:    wb_data = alu_out;
      default: wb_data = mem.dmem_rdata;
    endcase
  end

  // MUL holds X until its result is ready; memory ops hold X until accepted.
  assign stall    = val_x_reg & ((mul_req & (mul_state_reg != MUL_DONE)) |
                                 (mem_req & ~mem.dmem_reqrdy));
  assign retire   = val_x_reg & ~stall;
  assign rf_write = retire & rf_wen & (rd_addr != 5'd0);

  assign mem.imem_addr   = pc_f_reg;
  assign mem.dmem_reqval = val_x_reg & mem_req;
  assign mem.dmem_wen    = mem_wr;
  assign mem.dmem_addr   = alu_out;
  assign mem.dmem_wdata  = rs2_data;

  assign inst_X      = inst_x_reg;
  assign val_X       = val_x_reg;
  assign mul_busy    = mul_busy_reg;
  assign trace_val   = retire;
  assign trace_addr  = pc_x_reg;
  assign trace_wreg  = rf_write ? rd_addr : 5'd0;
  assign trace_wdata = wb_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_f_reg   <= RESET_PC;
      pc_x_reg   <= '0;
      inst_x_reg <= '0;
      val_x_reg  <= 1'b0;
    end else if (stall) begin
      pc_f_reg <= pc_f_reg;
    end else if (retire && (pc_sel != 2'd0)) begin
      pc_f_reg  <= target;
      val_x_reg <= 1'b0;
    end else begin
      pc_f_reg   <= pc_f_reg + 32'd4;
      inst_x_reg <= mem.imem_rdata;
      pc_x_reg   <= pc_f_reg;
      val_x_reg  <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rf_write) rf_reg[rd_addr] <= wb_data;
  end

  // One radix-2^MUL_STEP_BITS digit of the multiplier times the multiplicand.
  generate
    for (genvar gi = 0; gi < MUL_STEP_BITS; gi++) begin : g_pp
      assign pp_term[gi] = mplier_reg[gi] ? (mcand_reg << gi) : 32'd0;
    end
  endgenerate

  always_comb begin
    pp_sum = '0;
    for (int i = 0; i < MUL_STEP_BITS; i++) pp_sum = pp_sum + pp_term[i];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mul_state_reg <= MUL_IDLE;
      mul_cnt_reg   <= '0;
      mcand_reg     <= '0;
      mplier_reg    <= '0;
      acc_reg       <= '0;
      mul_busy_reg  <= 1'b0;
    end else begin
      case (mul_state_reg)
        MUL_IDLE: if (val_x_reg && mul_req) begin
          mul_state_reg <= MUL_BUSY;
          mul_busy_reg  <= 1'b1;
          mcand_reg     <= rs1_data;
          mplier_reg    <= rs2_data;
          acc_reg       <= '0;
          mul_cnt_reg   <= '0;
        end
        MUL_BUSY: begin
          acc_reg     <= acc_reg + pp_sum;
          mcand_reg   <= mcand_reg << MUL_STEP_BITS;
          mplier_reg  <= mplier_reg >> MUL_STEP_BITS;
          mul_cnt_reg <= mul_cnt_reg + CW'(1);
          if (mul_cnt_reg == CW'(N - 1)) mul_state_reg <= MUL_DONE;
        end
        default: begin
          mul_state_reg <= MUL_IDLE;
          mul_busy_reg  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_proc_pipe2_dpath.sv
// Directed bench: a small TinyRV1 decoder plays the control unit, programs run
// from a word-addressed instruction array, retirements are checked against tables.
module tb_proc_pipe2_dpath;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic       op2_sel;
    logic [1:0] wb_sel;
    logic [1:0] imm_type;
    logic       rf_wen;
    logic [1:0] pc_sel;
    logic       br;
    logic       alu_func;
    logic       mul_req;
    logic       mem_req;
    logic       mem_wr;
  } ctl_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] inst;
    logic [4:0]  wreg;
    logic [31:0] wdata;
  } vec_t;

  function automatic ctl_t decode(input logic [31:0] inst);
    ctl_t c;
    c = '0;
    case (inst[6:0])
      7'b0010011: begin c.op2_sel = 1; c.wb_sel = 2; c.rf_wen = 1; end
      7'b0110011: begin
        c.rf_wen = 1;
        if (inst[31:25] == 7'b0000001) begin c.mul_req = 1; c.wb_sel = 1; end
        else c.wb_sel = 2;
      end
      7'b0000011: begin c.op2_sel = 1; c.mem_req = 1; c.wb_sel = 3; c.rf_wen = 1; end
      7'b0100011: begin c.op2_sel = 1; c.imm_type = 1; c.mem_req = 1; c.mem_wr = 1; c.wb_sel = 2; end
      7'b1100011: begin c.alu_func = 1; c.imm_type = 3; c.wb_sel = 2; c.br = 1; end
      7'b1101111: begin c.imm_type = 2; c.wb_sel = 0; c.rf_wen = 1; c.pc_sel = 1; end
      7'b1100111: begin c.wb_sel = 0; c.rf_wen = 1; c.pc_sel = 2; end
      default: c = '0;
    endcase
    return c;
  endfunction

  function automatic logic [31:0] enc_addi(input int rd, input int rs1, input int imm);
    return {imm[11:0], rs1[4:0], 3'b000, rd[4:0], 7'b0010011};
  endfunction
  function automatic logic [31:0] enc_r(input logic [6:0] f7, input int rd, input int rs1, input int rs2);
    return {f7, rs2[4:0], rs1[4:0], 3'b000, rd[4:0], 7'b0110011};
  endfunction
  function automatic logic [31:0] enc_lw(input int rd, input int rs1, input int imm);
    return {imm[11:0], rs1[4:0], 3'b010, rd[4:0], 7'b0000011};
  endfunction
  function automatic logic [31:0] enc_sw(input int rs2, input int rs1, input int imm);
    return {imm[11:5], rs2[4:0], rs1[4:0], 3'b010, imm[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] enc_bne(input int rs1, input int rs2, input int imm);
    return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], 3'b001, imm[4:1], imm[11], 7'b1100011};
  endfunction
  function automatic logic [31:0] enc_jal(input int rd, input int imm);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'b1101111};
  endfunction

  logic [31:0] imem_mem [256];
  logic [31:0] dmem_mem [256];
  int          ready_delay = 0;
  int          wait_cnt = 0;

  proc_pipe2_dpath_if bus0 ();
  proc_pipe2_dpath_if bus1 ();

  ctl_t        c0, c1;
  logic [1:0]  pc_sel0, pc_sel1;
  logic [31:0] inst_x0, inst_x1, ta0, ta1, td0, td1;
  logic        val_x0, val_x1, alu_eq0, alu_eq1, stall0, stall1, busy0, busy1, tv0, tv1;
  logic [4:0]  tw0, tw1;

  always_comb c0 = decode(inst_x0);
  always_comb c1 = decode(inst_x1);
  assign pc_sel0 = c0.br ? (alu_eq0 ? 2'd0 : 2'd1) : c0.pc_sel;
  assign pc_sel1 = c1.br ? (alu_eq1 ? 2'd0 : 2'd1) : c1.pc_sel;

  assign bus0.imem_rdata  = imem_mem[bus0.imem_addr[9:2]];
  assign bus0.dmem_rdata  = dmem_mem[bus0.dmem_addr[9:2]];
  assign bus0.dmem_reqrdy = (wait_cnt >= ready_delay);
  assign bus1.imem_rdata  = imem_mem[bus1.imem_addr[9:2]];
  assign bus1.dmem_rdata  = dmem_mem[bus1.dmem_addr[9:2]];
  assign bus1.dmem_reqrdy = 1'b1;

  always @(posedge clk) begin
    if (bus0.dmem_reqval && !bus0.dmem_reqrdy) wait_cnt <= wait_cnt + 1;
    else wait_cnt <= 0;
    if (bus0.dmem_reqval && bus0.dmem_reqrdy && bus0.dmem_wen)
      dmem_mem[bus0.dmem_addr[9:2]] <= bus0.dmem_wdata;
  end

  proc_pipe2_dpath #(.RESET_PC(32'h200), .MUL_STEP_BITS(4)) u_dut (
    .clk(clk), .rst(rst), .mem(bus0),
    .op2_sel(c0.op2_sel), .wb_sel(c0.wb_sel), .imm_type(c0.imm_type), .rf_wen(c0.rf_wen),
    .pc_sel(pc_sel0), .alu_func(c0.alu_func), .mul_req(c0.mul_req), .mem_req(c0.mem_req),
    .mem_wr(c0.mem_wr), .inst_X(inst_x0), .val_X(val_x0), .alu_eq(alu_eq0), .stall(stall0),
    .mul_busy(busy0), .trace_val(tv0), .trace_addr(ta0), .trace_wreg(tw0), .trace_wdata(td0)
  );

  proc_pipe2_dpath #(.RESET_PC(32'h200), .MUL_STEP_BITS(1)) u_dut1 (
    .clk(clk), .rst(rst), .mem(bus1),
    .op2_sel(c1.op2_sel), .wb_sel(c1.wb_sel), .imm_type(c1.imm_type), .rf_wen(c1.rf_wen),
    .pc_sel(pc_sel1), .alu_func(c1.alu_func), .mul_req(c1.mul_req), .mem_req(c1.mem_req),
    .mem_wr(c1.mem_wr), .inst_X(inst_x1), .val_X(val_x1), .alu_eq(alu_eq1), .stall(stall1),
    .mul_busy(busy1), .trace_val(tv1), .trace_addr(ta1), .trace_wreg(tw1), .trace_wdata(td1)
  );

  // MUL occupancy / stall-cycle counters, keyed by the MUL's address.
  int occ0 = 0, stl0 = 0, occ_210 = 0, stl_210 = 0, occ_214 = 0, occ_208 = 0;
  int occ1 = 0, occ1_210 = 0;
  logic [31:0] wd1_210 = '0;
  bit seen1_210 = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      occ0 <= 0;
      stl0 <= 0;
    end else if (val_x0 && c0.mul_req) begin
      if (tv0) begin
        occ0 <= 0;
        stl0 <= 0;
        if (ta0 == 32'h210) begin occ_210 <= occ0 + 1; stl_210 <= stl0; end
        if (ta0 == 32'h214) occ_214 <= occ0 + 1;
        if (ta0 == 32'h208) occ_208 <= occ0 + 1;
      end else begin
        occ0 <= occ0 + 1;
        if (stall0) stl0 <= stl0 + 1;
      end
    end
  end

  always @(posedge clk) begin
    if (rst) occ1 <= 0;
    else if (val_x1 && c1.mul_req) begin
      if (tv1) begin
        occ1 <= 0;
        if (ta1 == 32'h210) begin occ1_210 <= occ1 + 1; wd1_210 <= td1; seen1_210 <= 1'b1; end
      end else occ1 <= occ1 + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%h want 0x%h", name, act, exp);
    end
  endtask

  task automatic wait_retire(input string name, input int budget, output bit ok);
    int c;
    c = 0;
    while (!tv0 && c < budget) begin
      @(negedge clk);
      c++;
    end
    ok = tv0;
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL %s: got no retirement within %0d cycles want a retirement", name, budget);
    end
  endtask

  task automatic clear_imem();
    for (int i = 0; i < 256; i++) imem_mem[i] = '0;
  endtask

  task automatic put(input logic [31:0] addr, input logic [31:0] inst);
    imem_mem[addr[9:2]] = inst;
  endtask

  vec_t tbl [14];
  int   rc  [14];

  initial begin
    bit ok;
    int c;

    tbl[0]  = '{32'h200, enc_addi(1, 0, 5),                  5'd1,  32'd5};
    tbl[1]  = '{32'h204, enc_r(7'b0000000, 2, 1, 1),         5'd2,  32'd10};
    tbl[2]  = '{32'h208, enc_addi(4, 0, 7),                  5'd4,  32'd7};
    tbl[3]  = '{32'h20C, enc_addi(5, 0, -1),                 5'd5,  32'hFFFF_FFFF};
    tbl[4]  = '{32'h210, enc_r(7'b0000001, 3, 4, 5),         5'd3,  32'hFFFF_FFF9};
    tbl[5]  = '{32'h214, enc_r(7'b0000001, 6, 2, 2),         5'd6,  32'd100};
    tbl[6]  = '{32'h218, enc_sw(3, 0, 16),                   5'd0,  32'd16};
    tbl[7]  = '{32'h21C, enc_lw(7, 0, 16),                   5'd7,  32'hFFFF_FFF9};
    tbl[8]  = '{32'h220, enc_addi(0, 0, 9),                  5'd0,  32'd9};
    tbl[9]  = '{32'h224, enc_r(7'b0000000, 8, 0, 0),         5'd8,  32'd0};
    tbl[10] = '{32'h228, enc_bne(1, 2, 8),                   5'd0,  32'd0};
    tbl[11] = '{32'h230, enc_bne(1, 1, 8),                   5'd0,  32'd1};
    tbl[12] = '{32'h234, enc_jal(10, 8),                     5'd10, 32'h238};
    tbl[13] = '{32'h23C, enc_addi(11, 10, 4),                5'd11, 32'h23C};

    // Program A: straight-line ALU, MUL, memory, x0 and branch/jump table.
    clear_imem();
    for (int i = 0; i < 14; i++) put(tbl[i].addr, tbl[i].inst);
    put(32'h22C, enc_addi(9, 0, 1));
    put(32'h238, enc_addi(9, 0, 2));
    put(32'h240, enc_jal(0, 0));

    repeat (2) @(negedge clk);
    chk("rst_imem_addr", bus0.imem_addr, 32'h200);
    chk("rst_val_x", {31'd0, val_x0}, 32'd0);
    chk("rst_stall", {31'd0, stall0}, 32'd0);
    chk("rst_mul_busy", {31'd0, busy0}, 32'd0);
    chk("rst_reqval", {31'd0, bus0.dmem_reqval}, 32'd0);
    chk("rst_trace_val", {31'd0, tv0}, 32'd0);
    chk("rst_inst_x", inst_x0, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("first_val_x", {31'd0, val_x0}, 32'd1);
    chk("first_pc_x", ta0, 32'h200);
    chk("first_imem_addr", bus0.imem_addr, 32'h204);

    for (int i = 0; i < 14; i++) begin
      wait_retire("tbl_retire", 60, ok);
      if (ok) begin
        rc[i] = cyc;
        $display("retire %0d addr=%h wreg=%0d wdata=%h", i, ta0, tw0, td0);
        chk("tbl_addr", ta0, tbl[i].addr);
        chk("tbl_wreg", {27'd0, tw0}, {27'd0, tbl[i].wreg});
        chk("tbl_wdata", td0, tbl[i].wdata);
        if (i < 2) chk("tbl_nostall", {31'd0, stall0}, 32'd0);
      end
      @(negedge clk);
    end
    chk("consec_retire", rc[1] - rc[0], 32'd1);
    chk("mul4_occupancy", occ_210, 32'd10);
    chk("mul4_stall_cycles", stl_210, 32'd9);
    chk("mul4_backtoback_occ", occ_214, 32'd10);

    c = 0;
    while (!seen1_210 && c < 300) begin @(negedge clk); c++; end
    chk("mul1_seen", {31'd0, seen1_210}, 32'd1);
    chk("mul1_occupancy", occ1_210, 32'd34);
    chk("mul1_result", wd1_210, 32'hFFFF_FFF9);

    // Program B: backward BNE squashes the fall-through slot.
    @(negedge clk);
    rst = 1'b1;
    clear_imem();
    put(32'h200, enc_addi(1, 0, 1));
    put(32'h204, enc_addi(2, 0, 2));
    put(32'h208, enc_bne(1, 2, -8));
    put(32'h20C, enc_addi(9, 0, 7));
    @(negedge clk);
    rst = 1'b0;
    c = 0;
    while (!(tv0 && ta0 == 32'h208) && c < 40) begin @(negedge clk); c++; end
    chk("bne_retired", {31'd0, tv0 && ta0 == 32'h208}, 32'd1);
    $display("retire bne addr=%h", ta0);
    @(negedge clk);
    chk("bne_pc_f", bus0.imem_addr, 32'h200);
    chk("bne_bubble_val", {31'd0, val_x0}, 32'd0);
    chk("bne_bubble_trace", {31'd0, tv0}, 32'd0);
    @(negedge clk);
    chk("bne_target_val", {31'd0, tv0}, 32'd1);
    chk("bne_target_addr", ta0, 32'h200);

    // Program C: store then load, each refused by memory for 3 cycles.
    @(negedge clk);
    rst = 1'b1;
    ready_delay = 3;
    clear_imem();
    put(32'h200, enc_addi(1, 0, 32'h40));
    put(32'h204, enc_addi(5, 0, 32'h123));
    put(32'h208, enc_sw(5, 1, 4));
    put(32'h20C, enc_lw(2, 1, 4));
    put(32'h210, enc_addi(3, 0, 1));
    put(32'h214, enc_jal(0, 0));
    @(negedge clk);
    rst = 1'b0;
    c = 0;
    while (!(val_x0 && inst_x0 == enc_lw(2, 1, 4)) && c < 40) begin @(negedge clk); c++; end
    chk("lw_reached_x", {31'd0, val_x0 && inst_x0 == enc_lw(2, 1, 4)}, 32'd1);
    for (int k = 0; k < 4; k++) begin
      $display("lw cycle %0d reqval=%0d rdy=%0d addr=%h stall=%0d", k, bus0.dmem_reqval,
               bus0.dmem_reqrdy, bus0.dmem_addr, stall0);
      chk("lw_reqval", {31'd0, bus0.dmem_reqval}, 32'd1);
      chk("lw_addr", bus0.dmem_addr, 32'h44);
      chk("lw_pc_f_frozen", bus0.imem_addr, 32'h210);
      chk("lw_stall", {31'd0, stall0}, {31'd0, k < 3});
      chk("lw_trace_val", {31'd0, tv0}, {31'd0, k == 3});
      if (k == 3) begin
        chk("lw_wreg", {27'd0, tw0}, 32'd2);
        chk("lw_wdata", td0, 32'h123);
      end
      @(negedge clk);
    end
    chk("after_lw_addr", ta0, 32'h210);
    chk("after_lw_val", {31'd0, tv0}, 32'd1);
    ready_delay = 0;

    // Program D: reset lands in the middle of a multiply.
    @(negedge clk);
    rst = 1'b1;
    clear_imem();
    put(32'h200, enc_addi(1, 0, 3));
    put(32'h204, enc_addi(2, 0, 4));
    put(32'h208, enc_r(7'b0000001, 3, 1, 2));
    put(32'h20C, enc_addi(4, 0, 5));
    put(32'h210, enc_jal(0, 0));
    @(negedge clk);
    rst = 1'b0;
    c = 0;
    while (!busy0 && c < 30) begin @(negedge clk); c++; end
    chk("midmul_busy_seen", {31'd0, busy0}, 32'd1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midmul_rst_busy", {31'd0, busy0}, 32'd0);
    chk("midmul_rst_stall", {31'd0, stall0}, 32'd0);
    chk("midmul_rst_val", {31'd0, val_x0}, 32'd0);
    chk("midmul_rst_pc", bus0.imem_addr, 32'h200);
    chk("midmul_rst_trace", {31'd0, tv0}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    wait_retire("rerun_0", 10, ok);
    if (ok) begin
      $display("retire rerun addr=%h wreg=%0d wdata=%h", ta0, tw0, td0);
      chk("rerun_addr0", ta0, 32'h200);
      chk("rerun_wreg0", {27'd0, tw0}, 32'd1);
      chk("rerun_wdata0", td0, 32'd3);
    end
    @(negedge clk);
    wait_retire("rerun_1", 10, ok);
    if (ok) chk("rerun_addr1", ta0, 32'h204);
    @(negedge clk);
    wait_retire("rerun_mul", 40, ok);
    if (ok) begin
      $display("retire rerun mul addr=%h wreg=%0d wdata=%h", ta0, tw0, td0);
      chk("rerun_mul_addr", ta0, 32'h208);
      chk("rerun_mul_wreg", {27'd0, tw0}, 32'd3);
      chk("rerun_mul_wdata", td0, 32'd12);
    end
    @(negedge clk);
    chk("rerun_mul_occ", occ_208, 32'd10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want test completion");
    $fatal(1);
  end
endmodule

// File: doc/proc_pipe2_dpath.md
Name: proc_pipe2_dpath

Overview:
Parametrised two-stage (Fetch / Execute) datapath for the TinyRV1 processor. It succeeds the single-cycle datapath and adds:
- an F/X pipeline register with squash on redirect
- an iterative multi-cycle multiplier with an internal FSM
- a val/rdy handshake on data memory, with an internally generated stall
The external control unit drives decoded control for the instruction in X. The block returns status and trace.

Parameters:
RESET_PC, 32'h00000200, PC value loaded on reset.
MUL_STEP_BITS, 4, multiplier bits retired per cycle; must divide 32 (1, 2, 4, 8). N = 32/MUL_STEP_BITS.

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
imem_addr  out  32  fetch address, = pc_F
imem_rdata  in  32  instruction, combinational response to imem_addr
dmem_reqval  out  1  data request valid
dmem_reqrdy  in  1  data memory accepts request this cycle
dmem_wen  out  1  1 = store, 0 = load
dmem_addr  out  32  ALU result
dmem_wdata  out  32  rs2 data
dmem_rdata  in  32  load data, valid in the acceptance cycle
op2_sel  in  1  0 = rs2, 1 = immediate
wb_sel  in  2  0 = pc_X+4, 1 = mul result, 2 = ALU, 3 = dmem_rdata
imm_type  in  2  0 = I, 1 = S, 2 = J, 3 = B
rf_wen  in  1  write rd
pc_sel  in  2  0 = sequential, 1 = pc_X+imm, 2 = rs1 data
alu_func  in  1  0 = add, 1 = equality (out = {31'b0, in0==in1})
mul_req  in  1  X instruction is MUL
mem_req  in  1  X instruction is LW/SW
mem_wr  in  1  store when mem_req
inst_X  out  32  instruction in X
val_X  out  1  X holds a live instruction
alu_eq  out  1  ALU out[0] when alu_func = 1, else 0
stall  out  1  X is held this cycle
mul_busy  out  1  multiplier FSM not IDLE
trace_val  out  1  X retires this cycle
trace_addr  out  32  pc_X
trace_wreg  out  5  rd if write occurs, else 0
trace_wdata  out  32  writeback data

Behaviour:
Reset (async, any time, including mid-multiply):
- pc_F = RESET_PC; val_X = 0; inst_X = 0; pc_X = 0.
- Multiplier FSM = IDLE, counter = 0.
- Resulting outputs: dmem_reqval = 0, stall = 0, mul_busy = 0, trace_val = 0.
- Register file contents are not reset. x0 always reads 0 and writes to it are discarded.

X stage (combinational from inst_X, pc_X):
- Regfile read of rs1 = [19:15] and rs2 = [24:20]; rd = [11:7].
- ImmGen uses standard TinyRV1 I/S/J/B sign-extended formats.
- Branch/jump target = pc_X + imm.

Stall:
- stall = val_X & ((mul_req & mul_state != DONE) | (mem_req & !dmem_reqrdy)).
- dmem_reqval = val_X & mem_req, held high until accepted. dmem_wen = mem_wr.

Retire:
- retire = val_X & !stall. trace_val = retire.
- Regfile write at clk edge when retire & rf_wen & rd != 0.
- Writes to rd = 0 report trace_wreg = 0.

F update each edge:
- stall: pc_F, inst_X, pc_X, val_X hold.
- retire & pc_sel != 0: pc_F <= target; val_X <= 0 (squashes the fetched instruction; one bubble).
- otherwise: pc_F <= pc_F + 4; inst_X <= imem_rdata; pc_X <= pc_F; val_X <= 1.

Multiplier FSM (IDLE, BUSY, DONE):
- IDLE -> BUSY when val_X & mul_req. Latches rs1/rs2 and clears accumulator and counter.
- BUSY: each cycle, acc += (multiplier low MUL_STEP_BITS × multiplicand) mod 2^32. Multiplicand shifts left by MUL_STEP_BITS; multiplier shifts right by MUL_STEP_BITS.
- BUSY -> DONE after N cycles.
- DONE: result drives wb input 1, stall drops, instruction retires, then -> IDLE.
- MUL occupies X for N+2 cycles: 10 at default.
- Result is the low 32 bits of the unsigned product, which equals the signed low half.
- A redirect never coincides with MUL, because the controller drives pc_sel = 0 for MUL.
- Back-to-back MULs: DONE -> IDLE, then the next MUL starts the following cycle.

Simultaneous events:
- A store that stalls performs no regfile write.
- mem_req and mul_req together is illegal; behaviour is undefined and not verified.

Test Plan:
- Reset with RESET_PC=0x200 -> imem_addr=0x200, val_X=0; after 1 cycle val_X=1, pc_X=0x200, imem_addr=0x204.
- ADDI x1,x0,5 then ADD x2,x1,x1 -> trace wreg 1/wdata 5, then wreg 2/wdata 10 on consecutive cycles; no stall.
- MUL x3,x1,x2 with x1=7, x2=0xFFFFFFFF, MUL_STEP_BITS=4 -> stall high 9 cycles, trace_wdata=0xFFFFFFF9 on the 10th cycle; repeat with MUL_STEP_BITS=1 -> 34-cycle occupancy.
- LW with dmem_reqrdy low 3 cycles -> dmem_reqval and dmem_addr held steady for 4 cycles, write on the acceptance cycle, pc_F frozen throughout.
- BNE taken (pc_X=0x208, imm=-8) -> pc_F=0x200 next cycle, following slot val_X=0, no trace for the squashed instruction.
- Assert rst during BUSY cycle 3 -> mul_busy=0, stall=0, val_X=0 immediately; after release, fetch restarts at RESET_PC and no stale write occurs.
